ptp_ts_capture: RTL and testbench
=================================

// Module: ptp_ts_capture
// PURPOSE
//  Upstream feeder for the 80-bit timestamp FIFO on the TX path. Snoops the MAC TX Avalon-ST stream,
//  latches time-of-day at each start-of-packet, classifies the frame as a PTP event message
//  (EtherType 0x88F7, optional single VLAN tag, messageType 0..3) and pushes the corrected timestamp
//  into the FIFO write port. Runs entirely in the FIFO write-clock domain; never backpressures the stream.
// PARAMETERS
//  LAT_NS     default 0      fixed TX path latency (ns) added to captured nanoseconds, 0..999_999_999
//  DROP_W     default 16     width of saturating drop counter
// PORTS
//  clk           in   1       FIFO write clock; all logic on rising edge
//  reset         in   1       synchronous, active-high
//  enable        in   1       0: no new frames captured; a frame already in flight completes normally
//  tod_in        in   80      time of day {seconds[47:0], nanoseconds[31:0]}, ns < 1e9
//  st_valid      in   1       stream beat valid (snoop only, no ready)
//  st_sop        in   1       first beat of frame, qualified by st_valid
//  st_eop        in   1       last beat of frame, qualified by st_valid
//  st_data       in   32      beat data, first byte on wire in [31:24]
//  ts_data       out  80      FIFO write data {seconds, ns}
//  ts_wrreq      out  1       FIFO write request, one-cycle pulse per accepted event frame
//  ts_wrfull     in   1       FIFO full flag
//  drop_cnt      out  DROP_W  event timestamps discarded because FIFO full; saturates at all-ones
// BEHAVIOUR
//  Reset: ts_data=0, ts_wrreq=0, drop_cnt=0, state=IDLE, beat counter=0.
//  Capture: on cycle with st_valid&st_sop&enable, register ts = tod_in + LAT_NS on ns field;
//   if ns+LAT_NS >= 1_000_000_000 then ns -= 1e9 and seconds += 1 (48-bit wrap at all-ones -> 0).
//   Beat counter set to 1 (SOP beat = beat 0). Correction computed combinationally, one register stage.
//  States: IDLE, PARSE, VLAN, PUSH, SKIP.
//   IDLE : SOP (enabled) -> PARSE.
//   PARSE: count valid beats; at beat 3 examine data[31:16]:
//          0x88F7 and data[11:8]<=3 -> PUSH; 0x88F7 and msgType>3 -> SKIP;
//          0x8100 -> VLAN; other -> SKIP.
//   VLAN : at beat 4, data[31:16]==0x88F7 and data[11:8]<=3 -> PUSH, else SKIP.
//   PUSH : single cycle. ts_wrfull=0 -> ts_wrreq=1, ts_data=captured ts; ts_wrfull=1 -> ts_wrreq=0,
//          drop_cnt+1 (saturating). Next -> SKIP, or IDLE if eop already seen in this frame.
//   SKIP : wait for st_valid&st_eop -> IDLE.
//  Decision beat that also carries eop: classification still applies; PUSH then goes to IDLE.
//  EOP before decision beat (runt) -> IDLE, no push, no drop count.
//  SOP while not IDLE (lost eop): abandon current frame (no push), restart capture from new SOP;
//   exception: in PUSH the pending push completes, and the new SOP is captured the same cycle.
//  Beats with st_valid=0 are ignored (counter holds). At most one push per frame.
//  ts_wrreq never asserted while ts_wrfull=1. ts_data holds last written value between pushes.
//  Reset mid-frame: returns to IDLE; remainder of frame ignored until next SOP.
//  Latency SOP->ts_wrreq: decision beat + 1 cycle (beat 3 -> next clk; VLAN beat 4 -> next clk).
// STRUCTURE
//  Shared package ptp_pkg: PTP_ETHERTYPE=16'h88F7, VLAN_TPID=16'h8100, NS_PER_SEC=32'd1_000_000_000,
//   typedef ptp_ts_t {seconds[47:0], ns[31:0]}, capture-state enum.
//  One sub-module: ptp_ts_add_ns (combinational ts + constant ns with carry into seconds), reused by RX path.
// TESTING
//  1. Untagged frame, beat3=0x88F7_0000 (Sync), tod={48'd5,32'd100}, LAT_NS=8 -> one ts_wrreq, ts_data={5,108}.
//  2. ns=999_999_995, LAT_NS=8 -> ts_data={seconds+1, 3}; seconds=all-ones -> seconds=0.
//  3. VLAN frame beat3=0x8100_xxxx, beat4=0x88F7_0300 -> push; msgType 0xB (Announce) -> no push.
//  4. EtherType 0x0800 and runt frame (eop on beat 2) -> no ts_wrreq, drop_cnt unchanged.
//  5. ts_wrfull=1 during PUSH for 3 event frames -> no wrreq, drop_cnt=3; DROP_W=2 with 5 drops -> 3.
//  6. SOP without prior eop mid-PARSE, plus reset asserted mid-frame -> only new frame pushed, correct ts.

Source files
------------

// File: rtl/ptp_pkg.sv
// Shared PTP timestamp definitions for the TX/RX capture paths.
package ptp_pkg;

    localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
    localparam logic [15:0] VLAN_TPID     = 16'h8100;
    localparam logic [31:0] NS_PER_SEC    = 32'd1_000_000_000;

    typedef struct packed {
        logic [47:0] seconds;
        logic [31:0] ns;
    } ptp_ts_t;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_PARSE,
        CAP_VLAN,
        CAP_PUSH,
        CAP_SKIP
    } cap_state_t;

    // EtherType/messageType word: PTP EtherType with an event messageType (0..3).
    function automatic logic is_event(input logic [31:0] d);
        return (d[31:16] == PTP_ETHERTYPE) && (d[11:8] <= 4'd3);
    endfunction

endpackage

// File: rtl/ptp_ts_add_ns.sv
// Adds a constant nanosecond offset to a {seconds, ns} timestamp, carrying into seconds.
module ptp_ts_add_ns import ptp_pkg::*; #(
    parameter int unsigned ADD_NS = 0
) (
    input  logic [79:0] ts_in,
    output logic [79:0] ts_out
);

    ptp_ts_t     t_in;
    ptp_ts_t     t_out;
    logic [32:0] ns_sum;

    assign t_in = ts_in;

    always_comb begin
        ns_sum = {1'b0, t_in.ns} + 33'(ADD_NS);
        t_out  = t_in;
        // Both operands are below 1e9, so at most one second of carry is possible.
        if (ns_sum >= {1'b0, NS_PER_SEC}) begin
            t_out.ns      = 32'(ns_sum - {1'b0, NS_PER_SEC});
            t_out.seconds = t_in.seconds + 48'd1;
        end else begin
            t_out.ns = ns_sum[31:0];
        end
    end

    assign ts_out = t_out;

endmodule

// File: rtl/ptp_ts_capture.sv
// TX-path PTP event timestamp capture: snoops the MAC stream, classifies frames and
// feeds corrected start-of-packet timestamps to the timestamp FIFO write port.
module ptp_ts_capture import ptp_pkg::*; #(
    parameter int unsigned LAT_NS = 0,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [79:0]       tod_in,
    input  logic              st_valid,
    input  logic              st_sop,
    input  logic              st_eop,
    input  logic [31:0]       st_data,
    output logic [79:0]       ts_data,
    output logic              ts_wrreq,
    input  logic              ts_wrfull,
    output logic [DROP_W-1:0] drop_cnt
);

    cap_state_t  state, state_nxt;
    logic [2:0]  beat, beat_nxt;
    logic        eop_seen, eop_seen_nxt;
    logic [79:0] tod_corr;
    logic [79:0] cap_ts;
    logic [79:0] last_ts;
    logic        sop_any, sop_cap, eop_beat, ev_beat, is_push;

    ptp_ts_add_ns #(.ADD_NS(LAT_NS)) u_add (
        .ts_in  (tod_in),
        .ts_out (tod_corr)
    );

    assign sop_any  = st_valid & st_sop;
    assign sop_cap  = sop_any & enable;
    assign eop_beat = st_valid & st_eop;
    assign ev_beat  = is_event(st_data);
    assign is_push  = (state == CAP_PUSH);

    // Write request and data come straight from PUSH so a full flag raised in that
    // very cycle still suppresses the request; ts_data otherwise shows the last write.
    assign ts_wrreq = is_push & ~ts_wrfull;
    assign ts_data  = ts_wrreq ? cap_ts : last_ts;

    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat;
        eop_seen_nxt = eop_seen;
        if (sop_cap) begin
            // A new SOP always restarts capture; a pending PUSH still fires this cycle.
            state_nxt    = st_eop ? CAP_IDLE : CAP_PARSE;
            beat_nxt     = 3'd1;
            eop_seen_nxt = 1'b0;
        end else if (sop_any) begin
            state_nxt = CAP_IDLE;
        end else begin
            case (state)
                CAP_IDLE: state_nxt = CAP_IDLE;
                CAP_PARSE: begin
                    if (st_valid) begin
                        if (beat == 3'd3) begin
                            eop_seen_nxt = st_eop;
                            beat_nxt     = 3'd4;
                            if (st_data[31:16] == VLAN_TPID)
                                state_nxt = st_eop ? CAP_IDLE : CAP_VLAN;
                            else if (ev_beat)
                                state_nxt = CAP_PUSH;
                            else
                                state_nxt = st_eop ? CAP_IDLE : CAP_SKIP;
                        end else if (st_eop) begin
                            state_nxt = CAP_IDLE;
                        end else begin
                            beat_nxt = beat + 3'd1;
                        end
                    end
                end
                CAP_VLAN: begin
                    if (st_valid) begin
                        eop_seen_nxt = st_eop;
                        if (ev_beat)
                            state_nxt = CAP_PUSH;
                        else
                            state_nxt = st_eop ? CAP_IDLE : CAP_SKIP;
                    end
                end
                CAP_PUSH: state_nxt = (eop_seen | eop_beat) ? CAP_IDLE : CAP_SKIP;
                CAP_SKIP: if (eop_beat) state_nxt = CAP_IDLE;
                default:  state_nxt = CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CAP_IDLE;
            beat     <= '0;
            eop_seen <= 1'b0;
            cap_ts   <= '0;
            last_ts  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            eop_seen <= eop_seen_nxt;
            if (sop_cap)
                cap_ts <= tod_corr;
            if (ts_wrreq)
                last_ts <= cap_ts;
            if (is_push && ts_wrfull && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ptp_ts_capture.sv
// Randomized bench for ptp_ts_capture against a frame-level behavioural model.
module tb_ptp_ts_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, st_valid, st_sop, st_eop, ts_wrfull;
    logic [79:0] tod_in;
    logic [31:0] st_data;
    logic [79:0] ts_data, ts_data2;
    logic        ts_wrreq, ts_wrreq2;
    logic [15:0] drop_cnt;
    logic [1:0]  drop_cnt2;

    int errors = 0;
    int checks = 0;
    int push_cnt = 0;
    int push_beat = -1;
    int cur_beat = -1;
    int exp_drops = 0;
    int wr_while_full = 0;
    logic [79:0] push_ts = '0;
    logic [79:0] last_exp_ts = '0;

    ptp_ts_capture #(.LAT_NS(8), .DROP_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .tod_in(tod_in),
        .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_data(st_data),
        .ts_data(ts_data), .ts_wrreq(ts_wrreq), .ts_wrfull(ts_wrfull), .drop_cnt(drop_cnt)
    );

    ptp_ts_capture #(.LAT_NS(8), .DROP_W(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .tod_in(tod_in),
        .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_data(st_data),
        .ts_data(ts_data2), .ts_wrreq(ts_wrreq2), .ts_wrfull(ts_wrfull), .drop_cnt(drop_cnt2)
    );

    // Reference: timestamp plus 8 ns, carried with div/mod arithmetic.
    function automatic logic [79:0] exp_ts(input logic [79:0] tod);
        longint unsigned total, carry, ns;
        logic [47:0] sec;
        total = longint'(tod[31:0]) + 8;
        carry = total / 1_000_000_000;
        ns    = total % 1_000_000_000;
        sec   = tod[79:32] + 48'(carry);
        return {sec, 32'(ns)};
    endfunction

    function automatic logic [79:0] rand_tod();
        return {16'($urandom), 32'($urandom), 32'($urandom_range(999_999_999, 0))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (ts_wrreq === 1'b1) begin
            push_cnt++;
            push_ts   = ts_data;
            push_beat = cur_beat;
        end
        if (ts_wrreq === 1'b1 && ts_wrfull === 1'b1)
            wr_while_full++;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d,
                         input logic [79:0] tod, input int b);
        st_valid = v; st_sop = s; st_eop = e; st_data = d; tod_in = tod; cur_beat = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), $urandom, rand_tod(), -1);
    endtask

    task automatic do_reset();
        reset = 1'b1; ts_wrfull = 1'b0;
        idle(2);
        reset = 1'b0;
        exp_drops = 0;
    endtask

    task automatic check_drops(input string name);
        logic [1:0] exp2;
        exp2 = (exp_drops > 3) ? 2'd3 : 2'(exp_drops);
        checks++;
        if (drop_cnt !== 16'(exp_drops)) begin
            errors++;
            $display("FAIL %s drop_cnt: got %0d expected %0d", name, drop_cnt, exp_drops);
        end
        checks++;
        if (drop_cnt2 !== exp2) begin
            errors++;
            $display("FAIL %s drop_cnt(W=2): got %0d expected %0d", name, drop_cnt2, exp2);
        end
    endtask

    // Drives one frame (optional idle gaps) and checks push count, timestamp, latency, drops.
    task automatic send_frame(input string name, input int n, input logic [31:0] w3,
                              input logic [31:0] w4, input logic [79:0] tod, input logic full,
                              input logic en_sop, input logic en_rest, input int maxgap);
        logic [31:0] beats[$];
        logic ev;
        int dec, exp_push;
        for (int i = 0; i < n; i++) beats.push_back($urandom);
        if (n > 3) beats[3] = w3;
        if (n > 4) beats[4] = w4;
        ev = 1'b0; dec = -1;
        if (en_sop && n > 3) begin
            if (beats[3][31:16] == 16'h88F7) begin
                if (beats[3][11:8] <= 4'd3) begin ev = 1'b1; dec = 3; end
            end else if (beats[3][31:16] == 16'h8100 && n > 4 &&
                         beats[4][31:16] == 16'h88F7 && beats[4][11:8] <= 4'd3) begin
                ev = 1'b1; dec = 4;
            end
        end
        exp_push = (ev && !full) ? 1 : 0;
        if (ev && full) exp_drops++;

        ts_wrfull = full;
        push_cnt  = 0;
        push_beat = -1;
        for (int i = 0; i < n; i++) begin
            enable = (i == 0) ? en_sop : en_rest;
            drive(1'b1, i == 0, i == n - 1, beats[i], (i == 0) ? tod : rand_tod(), i);
            if (i < n - 1 && maxgap > 0) idle($urandom_range(maxgap, 0));
        end
        enable = 1'b1;

        checks++;
        if (push_cnt !== exp_push) begin
            errors++;
            $display("FAIL %s push count: got %0d expected %0d", name, push_cnt, exp_push);
        end
        if (exp_push == 1) begin
            last_exp_ts = exp_ts(tod);
            checks++;
            if (push_ts !== last_exp_ts) begin
                errors++;
                $display("FAIL %s ts_data: got %h expected %h", name, push_ts, last_exp_ts);
            end
            checks++;
            if (push_beat !== dec) begin
                errors++;
                $display("FAIL %s latency: push after beat %0d expected beat %0d", name, push_beat, dec);
            end
        end
        check_drops(name);
        checks++;
        if (wr_while_full !== 0) begin
            errors++;
            $display("FAIL %s wrreq while full: got %0d expected 0", name, wr_while_full);
        end
    endtask

    task automatic check_hold(input string name);
        idle(3);
        checks++;
        if (ts_data !== last_exp_ts) begin
            errors++;
            $display("FAIL %s ts_data hold: got %h expected %h", name, ts_data, last_exp_ts);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0;
        tod_in = '0; ts_wrfull = 1'b0; reset = 1'b1;
        idle(3);
        checks++;
        if (ts_data !== 80'd0 || ts_wrreq !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got ts_data=%h wrreq=%b expected 0/0", ts_data, ts_wrreq);
        end
        reset = 1'b0;
        exp_drops = 0;
        check_drops("reset");
    endtask

    task automatic test_sync();
        send_frame("sync", 6, 32'h88F7_0000, $urandom, {48'd5, 32'd100}, 1'b0, 1'b1, 1'b1, 0);
        check_hold("sync");
        send_frame("sync_gaps", 8, 32'h88F7_0200, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 3);
    endtask

    task automatic test_ns_wrap();
        send_frame("ns_wrap", 5, 32'h88F7_0100, $urandom, {48'd7, 32'd999_999_995}, 1'b0, 1'b1, 1'b1, 1);
        send_frame("sec_wrap", 5, 32'h88F7_0100, $urandom, {48'hFFFF_FFFF_FFFF, 32'd999_999_995},
                   1'b0, 1'b1, 1'b1, 0);
        send_frame("ns_edge", 5, 32'h88F7_0000, $urandom, {48'd9, 32'd999_999_991}, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_vlan();
        send_frame("vlan_event", 7, 32'h8100_0123, 32'h88F7_0300, rand_tod(), 1'b0, 1'b1, 1'b1, 2);
        send_frame("vlan_announce", 7, 32'h8100_0123, 32'h88F7_0B00, rand_tod(), 1'b0, 1'b1, 1'b1, 2);
        send_frame("vlan_eop_dec", 5, 32'h8100_0456, 32'h88F7_0000, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
        idle(1);
    endtask

    task automatic test_nonevent();
        send_frame("ipv4", 8, 32'h0800_4500, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 1);
        send_frame("runt", 3, 32'h88F7_0000, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 1);
        send_frame("msg_general", 6, 32'h88F7_0800, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
        check_hold("nonevent");
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame("full", 6, 32'h88F7_0000, $urandom, rand_tod(), 1'b1, 1'b1, 1'b1, 1);
            idle(1);
        end
        send_frame("after_full", 6, 32'h88F7_0100, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_enable();
        send_frame("disabled", 6, 32'h88F7_0000, $urandom, rand_tod(), 1'b0, 1'b0, 1'b0, 0);
        send_frame("disable_inflight", 6, 32'h88F7_0000, $urandom, rand_tod(), 1'b0, 1'b1, 1'b0, 1);
    endtask

    task automatic test_lost_eop();
        ts_wrfull = 1'b0; enable = 1'b1;
        drive(1'b1, 1'b1, 1'b0, $urandom, rand_tod(), 0);
        drive(1'b1, 1'b0, 1'b0, $urandom, rand_tod(), 1);
        drive(1'b1, 1'b0, 1'b0, $urandom, rand_tod(), 2);
        send_frame("lost_eop", 6, 32'h88F7_0000, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
        idle(1);
        push_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, $urandom, rand_tod(), 0);
        drive(1'b1, 1'b0, 1'b0, $urandom, rand_tod(), 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_drops = 0;
        drive(1'b1, 1'b0, 1'b0, $urandom, rand_tod(), 2);
        drive(1'b1, 1'b0, 1'b0, 32'h88F7_0000, rand_tod(), 3);
        drive(1'b1, 1'b0, 1'b1, 32'h88F7_0000, rand_tod(), 4);
        checks++;
        if (push_cnt !== 0) begin
            errors++;
            $display("FAIL reset_midframe push count: got %0d expected 0", push_cnt);
        end
        send_frame("post_reset", 6, 32'h88F7_0300, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        // Decision beat carries EOP and the next SOP lands in the PUSH cycle.
        send_frame("b2b_a", 4, 32'h88F7_0000, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
        send_frame("b2b_b", 4, 32'h88F7_0100, $urandom, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
        send_frame("b2b_c", 5, 32'h8100_0001, 32'h88F7_0200, rand_tod(), 1'b0, 1'b1, 1'b1, 0);
        idle(1);
    endtask

    task automatic test_random();
        int kind, n;
        logic [31:0] w3, w4;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(5, 0);
            n    = $urandom_range(10, 4);
            w3   = $urandom;
            w4   = $urandom;
            case (kind)
                0: w3 = {16'h88F7, 4'($urandom), 4'($urandom_range(3, 0)), 8'($urandom)};
                1: w3 = {16'h88F7, 4'($urandom), 4'($urandom_range(15, 4)), 8'($urandom)};
                2: begin w3 = {16'h8100, 16'($urandom)};
                         w4 = {16'h88F7, 4'($urandom), 4'($urandom_range(3, 0)), 8'($urandom)}; end
                3: begin w3 = {16'h8100, 16'($urandom)};
                         w4 = {16'h88F7, 4'($urandom), 4'($urandom_range(15, 4)), 8'($urandom)}; end
                4: w3 = {16'h0800, 16'($urandom)};
                default: n = $urandom_range(3, 1);
            endcase
            send_frame("random", n, w3, w4, rand_tod(), ($urandom_range(3, 0) == 0), 1'b1, 1'b1, 2);
            idle($urandom_range(2, 0));
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_ns_wrap();
        test_vlan();
        test_nonevent();
        test_full();
        test_enable();
        test_lost_eop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
